// File: rtl/deserialize_pkg.sv
// Shared beat-packing helpers for the serialize/deserialize argument path.
// Both sides derive tag width and field offsets from here so the packing always agrees.
package deserialize_pkg;

  localparam int unsigned DATA_LSB = 0;

  function automatic int unsigned tag_width(input int unsigned argn);
    return $clog2(argn);
  endfunction

  function automatic int unsigned beat_width(input int unsigned argw, input int unsigned argn);
    return tag_width(argn) + argw;
  endfunction

  function automatic int unsigned tag_msb(input int unsigned argw, input int unsigned argn);
    return beat_width(argw, argn) - 1;
  endfunction

  function automatic int unsigned tag_lsb(input int unsigned argw);
    return argw;
  endfunction

endpackage

// File: rtl/deserialize_if.sv
// Argument-in / result-out handshake bundle for deserialize.
interface deserialize_if #(
  parameter int unsigned ARGW = 16,
  parameter int unsigned ARGN = 2
);
  import deserialize_pkg::*;

  localparam int unsigned TAGW = tag_width(ARGN);

  logic                   arg_stb;
  logic [TAGW+ARGW-1:0]   arg_dat;
  logic                   arg_rdy;
  logic                   res_stb;
  logic [ARGN*ARGW-1:0]   res_dat;
  logic                   res_rdy;
  logic                   err_stb;

  modport master (
    output arg_stb, arg_dat, res_rdy,
    input  arg_rdy, res_stb, res_dat, err_stb
  );

  modport slave (
    input  arg_stb, arg_dat, res_rdy,
    output arg_rdy, res_stb, res_dat, err_stb
  );

endinterface

// File: rtl/deserialize.sv
// Gathers tagged argument beats into ARGN slots and emits the full vector once every slot
// is filled; out-of-range tags are dropped with a one-cycle error pulse.
module deserialize
  import deserialize_pkg::*;
#(
  parameter int unsigned ARGW = 16,
  parameter int unsigned ARGN = 2
) (
  input  logic           clk,
  input  logic           rst,
  deserialize_if.slave   bus
);

  localparam int unsigned TAGW    = tag_width(ARGN);
  localparam int unsigned TAG_MSB = tag_msb(ARGW, ARGN);
  localparam int unsigned TAG_LSB = tag_lsb(ARGW);

  logic [ARGW-1:0]      r_slot [ARGN];
  logic [ARGN-1:0]      r_msk;
  logic                 r_res_stb;
  logic [ARGN*ARGW-1:0] r_res_dat;
  logic                 r_err_stb;

  logic [TAGW-1:0]      w_tag;
  logic [ARGW-1:0]      w_word;
  logic                 w_in_range;
  logic [ARGN-1:0]      w_hit;
  logic                 w_dup;
  logic                 w_last;
  logic                 w_out_free;
  logic                 w_arg_rdy;
  logic                 w_acc;
  logic                 w_load;
  logic [ARGN*ARGW-1:0] w_merged;

  assign w_tag      = bus.arg_dat[TAG_MSB:TAG_LSB];
  assign w_word     = bus.arg_dat[DATA_LSB +: ARGW];
  assign w_in_range = 32'(w_tag) < ARGN;

  always_comb begin
    w_hit = '0;
    for (int n = 0; n < int'(ARGN); n++) begin
      w_hit[n] = w_in_range && (w_tag == TAGW'(n));
    end
  end

  assign w_dup      = |(r_msk & w_hit);
  assign w_last     = ((r_msk | w_hit) == {ARGN{1'b1}}) && (w_hit != '0);
  assign w_out_free = ~r_res_stb | bus.res_rdy;

  // Only the completing beat (or a duplicate tag) ever waits on the output.
  always_comb begin
    w_arg_rdy = 1'b1;
    if (w_in_range) begin
      if (w_dup) begin
        w_arg_rdy = 1'b0;
      end else if (w_last) begin
        w_arg_rdy = w_out_free;
      end
    end
  end

  assign w_acc  = bus.arg_stb & w_arg_rdy;
  assign w_load = w_acc & w_last;

  // The completing word bypasses the slot store straight into the result.
  always_comb begin
    w_merged = '0;
    for (int n = 0; n < int'(ARGN); n++) begin
      w_merged[n*ARGW +: ARGW] = w_hit[n] ? w_word : r_slot[n];
    end
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < int'(ARGN); n++) begin
      if (w_acc && w_hit[n]) begin
        r_slot[n] <= w_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_msk     <= '0;
      r_res_stb <= 1'b0;
      r_res_dat <= '0;
      r_err_stb <= 1'b0;
    end else begin
      r_err_stb <= w_acc & ~w_in_range;
      if (w_load) begin
        r_res_dat <= w_merged;
        r_res_stb <= 1'b1;
        r_msk     <= '0;
      end else begin
        if (w_acc) begin
          r_msk <= r_msk | w_hit;
        end
        if (r_res_stb && bus.res_rdy) begin
          r_res_stb <= 1'b0;
        end
      end
    end
  end

  assign bus.arg_rdy = w_arg_rdy;
  assign bus.res_stb = r_res_stb;
  assign bus.res_dat = r_res_dat;
  assign bus.err_stb = r_err_stb;

endmodule

// File: tb/tb_deserialize.sv
// Bench for deserialize: directed handshake cases on ARGN=2 and ARGN=3 instances, then
// random-order streaming scored against a queue of expected vectors.
module tb_deserialize;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  deserialize_if #(.ARGW(16), .ARGN(2)) a_if ();
  deserialize_if #(.ARGW(16), .ARGN(3)) b_if ();

  deserialize #(.ARGW(16), .ARGN(2)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  deserialize #(.ARGW(16), .ARGN(3)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_pop  = 0;
  bit          mon_en = 1'b0;
  bit          rdy_rand = 1'b0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic t, input logic [15:0] w, input int limit);
    bit ok;
    ok = 1'b0;
    a_if.arg_stb = 1'b1;
    a_if.arg_dat = {t, w};
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      ok = a_if.arg_rdy;
    end
    if (!ok) check("accept_timeout_a", 64'(ok), 64'd1);
    tick();
    a_if.arg_stb = 1'b0;
  endtask

  task automatic send_b(input logic [1:0] t, input logic [15:0] w, input int limit);
    bit ok;
    ok = 1'b0;
    b_if.arg_stb = 1'b1;
    b_if.arg_dat = {t, w};
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      ok = b_if.arg_rdy;
    end
    if (!ok) check("accept_timeout_b", 64'(ok), 64'd1);
    tick();
    b_if.arg_stb = 1'b0;
  endtask

  always @(posedge clk) begin
    if (rdy_rand) begin
      #1;
      a_if.res_rdy = 1'($urandom_range(0, 1));
    end
  end

  // Scoreboard: each result handshake must match the oldest outstanding set.
  always @(negedge clk) begin
    if (mon_en && a_if.res_stb && a_if.res_rdy) begin
      if (exp_q.size() == 0) begin
        check("stream_extra", 64'd1, 64'd0);
      end else begin
        check("stream_vec", 64'(a_if.res_dat), 64'(exp_q.pop_front()));
        n_pop++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] w0;
    logic [15:0] w1;

    rst = 1'b1;
    a_if.arg_stb = 1'b0;
    a_if.arg_dat = '0;
    a_if.res_rdy = 1'b1;
    b_if.arg_stb = 1'b0;
    b_if.arg_dat = '0;
    b_if.res_rdy = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("rst_res_stb", 64'(a_if.res_stb), 64'd0);
    check("rst_res_dat", 64'(a_if.res_dat), 64'd0);
    check("rst_err_stb", 64'(a_if.err_stb), 64'd0);
    check("rst_arg_rdy", 64'(a_if.arg_rdy), 64'd1);

    // In-order pair.
    send_a(1'b0, 16'h1234, 4);
    send_a(1'b1, 16'hABCD, 4);
    check("pair_stb", 64'(a_if.res_stb), 64'd1);
    check("pair_dat", 64'(a_if.res_dat), 64'hABCD_1234);
    tick();
    check("pair_stb_fall", 64'(a_if.res_stb), 64'd0);
    a_if.arg_dat = {1'b0, 16'h0};
    #1;
    check("pair_msk_clr0", 64'(a_if.arg_rdy), 64'd1);
    a_if.arg_dat = {1'b1, 16'h0};
    #1;
    check("pair_msk_clr1", 64'(a_if.arg_rdy), 64'd1);

    // Reverse order with a duplicate tag.
    send_a(1'b1, 16'h0002, 4);
    a_if.arg_dat = {1'b1, 16'h0003};
    #1;
    check("dup_stall", 64'(a_if.arg_rdy), 64'd0);
    send_a(1'b0, 16'h0001, 4);
    check("rev_dat", 64'(a_if.res_dat), 64'h0002_0001);
    send_a(1'b1, 16'h0003, 1);
    send_a(1'b0, 16'h0004, 4);
    check("dup_then_dat", 64'(a_if.res_dat), 64'h0003_0004);
    tick();

    // Output stall, then same-cycle ack and load.
    a_if.res_rdy = 1'b0;
    send_a(1'b0, 16'h1111, 4);
    send_a(1'b1, 16'h2222, 4);
    send_a(1'b0, 16'h5555, 2);
    a_if.arg_stb = 1'b1;
    a_if.arg_dat = {1'b1, 16'h6666};
    repeat (3) begin
      @(negedge clk);
      check("stall_rdy", 64'(a_if.arg_rdy), 64'd0);
    end
    check("stall_stb", 64'(a_if.res_stb), 64'd1);
    check("stall_dat", 64'(a_if.res_dat), 64'h2222_1111);
    tick();
    a_if.res_rdy = 1'b1;
    @(negedge clk);
    check("unstall_rdy", 64'(a_if.arg_rdy), 64'd1);
    tick();
    a_if.arg_stb = 1'b0;
    check("b2b_stb", 64'(a_if.res_stb), 64'd1);
    check("b2b_dat", 64'(a_if.res_dat), 64'h6666_5555);
    tick();
    check("b2b_fall", 64'(a_if.res_stb), 64'd0);

    // Reset mid-set with a result pending.
    a_if.res_rdy = 1'b0;
    send_a(1'b0, 16'h0001, 4);
    send_a(1'b1, 16'h0002, 4);
    send_a(1'b0, 16'h0AAA, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_stb", 64'(a_if.res_stb), 64'd0);
    check("mrst_dat", 64'(a_if.res_dat), 64'd0);
    a_if.res_rdy = 1'b1;
    send_a(1'b1, 16'h0BBB, 4);
    repeat (3) tick();
    check("mrst_no_result", 64'(a_if.res_stb), 64'd0);
    send_a(1'b0, 16'h0CCC, 4);
    check("mrst_after_stb", 64'(a_if.res_stb), 64'd1);
    check("mrst_after_dat", 64'(a_if.res_dat), 64'h0BBB_0CCC);
    tick();

    // Out-of-range tag on the three-slot instance.
    send_b(2'd0, 16'h0101, 4);
    check("oor_first_err", 64'(b_if.err_stb), 64'd0);
    b_if.arg_dat = {2'd3, 16'hFFFF};
    #1;
    check("oor_rdy", 64'(b_if.arg_rdy), 64'd1);
    send_b(2'd3, 16'hFFFF, 1);
    check("oor_err", 64'(b_if.err_stb), 64'd1);
    check("oor_no_res", 64'(b_if.res_stb), 64'd0);
    tick();
    check("oor_err_fall", 64'(b_if.err_stb), 64'd0);
    send_b(2'd1, 16'h0202, 4);
    send_b(2'd2, 16'h0303, 4);
    check("oor_set_stb", 64'(b_if.res_stb), 64'd1);
    check("oor_set_dat", 64'(b_if.res_dat), 64'h0303_0202_0101);
    tick();

    // Random-order streaming with random result back-pressure.
    mon_en   = 1'b1;
    rdy_rand = 1'b1;
    for (int s = 0; s < 100; s++) begin
      w0 = 16'($urandom);
      w1 = 16'($urandom);
      exp_q.push_back({w1, w0});
      if ($urandom_range(0, 1) == 0) begin
        send_a(1'b0, w0, 200);
        send_a(1'b1, w1, 200);
      end else begin
        send_a(1'b1, w1, 200);
        send_a(1'b0, w0, 200);
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    rdy_rand = 1'b0;
    tick();
    a_if.res_rdy = 1'b1;
    repeat (2) tick();
    mon_en = 1'b0;
    check("stream_left", 64'(exp_q.size()), 64'd0);
    check("stream_count", 64'(n_pop), 64'd100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/deserialize.md
# deserialize

Collects tagged argument words from a single narrow stream back into a full-width parallel vector. It sits directly downstream of `serialize` in the argument path. Each input beat carries a slot tag in its upper bits and a data word in its lower bits. Once every one of the ARGN slots holds a word, the block emits all ARGN words together as one result beat and starts a new set.

## Interface
- `ARGW`, default 16: data word width per slot.
- `ARGN`, default 2: number of slots. Must be ≥ 2.
- Derived localparam `TAGW` = `$clog2(ARGN)`.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `arg_stb`  in  1  input beat valid.
- `arg_dat`  in  TAGW+ARGW  input beat: tag in `[TAGW+ARGW-1:ARGW]`, word in `[ARGW-1:0]`.
- `arg_rdy`  out  1  input beat accepted when `arg_stb & arg_rdy`.
- `res_stb`  out  1  result vector valid (registered).
- `res_dat`  out  ARGN*ARGW  slot n in `[n*ARGW +: ARGW]` (registered).
- `res_rdy`  in  1  result consumed when `res_stb & res_rdy`.
- `err_stb`  out  1  one-cycle pulse: an out-of-range tag was discarded (registered).

## Operation
- State:
  - slot store `slot[ARGN]`, each ARGW bits.
  - fill mask `msk[ARGN-1:0]`.
  - output register `res_stb`/`res_dat`.
  - `err_stb`.
- Reset values: `msk`=0, `res_stb`=0, `res_dat`=0, `err_stb`=0. Slot contents are don't-care.
- Definitions:
  - tag = `arg_dat[TAGW+ARGW-1:ARGW]`.
  - hit = onehot(tag) when tag < ARGN, else 0.
  - `last` = ((`msk` | hit) == all-ones) & (hit != 0).
  - `out_free` = `~res_stb | res_rdy`.
- `arg_rdy` (combinational):
  - tag ≥ ARGN: 1.
  - `msk[tag]`=1: 0. A duplicate tag stalls until the current set is flushed.
  - `last`: `out_free`.
  - otherwise: 1.
- On accept with tag ≥ ARGN: word discarded, `msk` unchanged, `err_stb` <= 1 for exactly one cycle.
- On accept, non-last: `slot[tag]` <= word; `msk[tag]` <= 1.
- On accept, last:
  - `res_dat` <= stored slots with the incoming word merged into slot `tag`.
  - `res_stb` <= 1.
  - `msk` <= 0.
- Output handshake:
  - `res_stb` falls on `res_stb & res_rdy` unless a new last beat loads the register in the same cycle, in which case it stays 1 with the new data.
  - `res_dat` is stable while `res_stb & ~res_rdy`.
- Slots may arrive in any order. Arrival order does not affect `res_dat` layout.

## Timing
- Latency: last beat accepted at edge t → `res_stb`=1 with the full vector after edge t. Registered output, one cycle.
- Throughput: one input beat per cycle. One result per ARGN accepted in-range beats.
- Back-pressure applies only to the completing beat (or a duplicate tag); non-completing beats are accepted while the output is stalled.
- Simultaneous result ack and last-beat accept: both happen, giving back-to-back result beats with no bubble.
- `rst` mid-set discards partial slots (`msk`=0) and any pending result (`res_stb`=0). `arg_rdy` is evaluated from post-reset state on the following cycle.
- `arg_rdy` depends combinationally on `arg_dat` and `res_rdy`. Upstream must hold `arg_stb`/`arg_dat` stable until accepted.

## Structure
- Single flat module. No sub-module needed; the slot store is a plain register array.
- Shared package/header:
  - tag-width function/macro (`$clog2(ARGN)`).
  - beat field offsets (tag MSB position, data LSB=0), shared with `serialize` so both sides agree on the packing.

## Test plan
(ARGW=16, ARGN=2 unless stated.)
- In-order pair: `{0,0x1234}` then `{1,0xABCD}`, `res_rdy`=1 → `res_stb` one cycle after the second beat, `res_dat`=0xABCD_1234. `msk` returns to 0.
- Reverse order plus duplicate: `{1,0x0002}`, then `{1,0x0003}` → `arg_rdy`=0 on the duplicate until `{0,0x0001}` completes the set. Result 0x0002_0001, then 0x0003 is accepted into slot 1.
- Output stall: `res_rdy`=0 with a result pending. `{0,0x5555}` is accepted. `{1,0x6666}` is held with `arg_rdy`=0 until `res_rdy`=1. Then same-cycle ack and load → `res_stb` stays 1, `res_dat`=0x6666_5555.
- Out-of-range tag (ARGN=3, TAGW=2): `{3,0xFFFF}` → `arg_rdy`=1, `err_stb` pulses one cycle, `msk` unchanged, no result.
- Reset mid-set: accept `{0,0x0AAA}`, assert `rst` one cycle → `msk`=0, `res_stb`=0. Then `{1,0x0BBB}` alone produces no result.
- Streaming: 100 random-order complete sets with random `res_rdy` → scoreboard matches every vector, with no loss or duplication.
